// File: rtl/mpc_pkg.sv
// rtl/mpc_pkg.sv - shared defaults, FSM state type and header block-count helper
//
// Purpose : constants and types shared between the output-port responder and
//           the requester side of the multi-port cache.
// Contents: PORTNUM/DWIDTH/RAMWIDTH defaults, state_t enum, hdr_blocks().

package mpc_pkg;

  localparam int PORTNUM_DEF  = 16;
  localparam int DWIDTH_DEF   = 32;
  localparam int RAMWIDTH_DEF = 11;

  // Widest header block count: ceil((1023 + 4) / 64) = 17 fits in 5 bits.
  localparam int HDR_BLK_W = 5;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_RECV  = 2'd2
  } state_t;

  // Number of 64-byte cache blocks a packet occupies, where len is the
  // header length field and 4 extra bytes of framing travel with the packet.
  function automatic logic [HDR_BLK_W-1:0] hdr_blocks(input logic [9:0] len);
    return HDR_BLK_W'(({1'b0, len} + 11'd67) >> 6);
  endfunction

endpackage

// File: rtl/rr_arb16.sv
// rtl/rr_arb16.sv - round-robin arbiter, one-hot grant
//
// Purpose : pick one requester, searching upward from the channel after the
//           previous winner and wrapping around.
// Ports   : req_i  - request vector
//           last_i - index of the previous winner
//           gnt_o  - one-hot grant
//           vld_o  - any request granted

module rr_arb16 #(
  parameter  int N  = 16,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] last_i,
  output logic [N-1:0]  gnt_o,
  output logic          vld_o
);

  logic [IW-1:0] idx;

  always_comb begin
    gnt_o = '0;
    vld_o = 1'b0;
    idx   = '0;
    // k = N lands back on last_i, so a lone repeat requester still wins.
    for (int k = 1; k <= N; k++) begin
      idx = IW'((int'(last_i) + k) % N);
      if (!vld_o && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        vld_o      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/channel_resp.sv
// rtl/channel_resp.sv - output-port responder: grant, receive, space accounting
//
// Purpose : arbitrates PORTNUM requesters for one output port, streams the
//           granted channel toward the cache writer and tracks free blocks.
// Ports   : i_clk, i_rst_n                 - clock, async active-low reset
//           i_req / o_resp / o_nresp       - request, grant and refuse pulses
//           i_sop, i_data_vld, i_eop, i_data - per-channel input streams
//           o_ready                        - idle and able to grant
//           o_ramspace                     - free block count
//           i_free_vld, i_free_blocks      - blocks returned by the read side
//           o_wr_*, o_src_id               - stream toward the cache writer

module channel_resp
  import mpc_pkg::*;
#(
  parameter  int PORTNUM    = PORTNUM_DEF,
  parameter  int DWIDTH     = DWIDTH_DEF,
  parameter  int RAMWIDTH   = RAMWIDTH_DEF,
  parameter  int RAM_BLOCKS = 1024,
  parameter  int TIMEOUT    = 1023,
  localparam int SW         = $clog2(PORTNUM)
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [PORTNUM-1:0]        i_req,
  output logic [PORTNUM-1:0]        o_resp,
  output logic [PORTNUM-1:0]        o_nresp,
  input  logic [PORTNUM-1:0]        i_sop,
  input  logic [PORTNUM-1:0]        i_data_vld,
  input  logic [PORTNUM-1:0]        i_eop,
  input  logic [PORTNUM*DWIDTH-1:0] i_data,
  output logic                      o_ready,
  output logic [RAMWIDTH-1:0]       o_ramspace,
  input  logic                      i_free_vld,
  input  logic [RAMWIDTH-1:0]       i_free_blocks,
  output logic                      o_wr_en,
  output logic                      o_wr_sop,
  output logic                      o_wr_eop,
  output logic                      o_wr_abort,
  output logic [DWIDTH-1:0]         o_wr_data,
  output logic [SW-1:0]             o_src_id
);

  localparam int TW = $clog2(TIMEOUT + 1);
  // Two spare bits hold space + returned blocks + restored blocks unclipped.
  localparam int EW = RAMWIDTH + 2;
  localparam logic [RAMWIDTH-1:0] RAM_MAX = RAMWIDTH'(RAM_BLOCKS);

  state_t                 state_q, state_d;
  logic [SW-1:0]          last_q, last_d;
  logic [SW-1:0]          sel_q, sel_d;
  logic [SW-1:0]          src_id_q, src_id_d;
  logic [PORTNUM-1:0]     resp_q, resp_d;
  logic [PORTNUM-1:0]     nresp_q, nresp_d;
  logic                   wr_en_q, wr_en_d;
  logic                   wr_sop_q, wr_sop_d;
  logic                   wr_eop_q, wr_eop_d;
  logic                   wr_abort_q, wr_abort_d;
  logic [DWIDTH-1:0]      wr_data_q, wr_data_d;
  logic [RAMWIDTH-1:0]    space_q, space_d;
  logic                   hdr_seen_q, hdr_seen_d;
  logic [HDR_BLK_W-1:0]   hdr_blk_q, hdr_blk_d;
  logic [TW-1:0]          idle_cnt_q, idle_cnt_d;

  logic [PORTNUM-1:0]     arb_gnt;
  logic                   arb_vld;
  logic [SW-1:0]          gnt_idx;

  logic                   ch_vld, ch_sop, ch_eop;
  logic [DWIDTH-1:0]      ch_data;
  logic                   fwd, hdr_now, timeout_hit, underflow;
  logic [HDR_BLK_W-1:0]   hdr_blk_now;
  logic [EW-1:0]          add_sum, sub_amt, net;

  rr_arb16 #(.N(PORTNUM)) u_arb (
    .req_i  (i_req),
    .last_i (last_q),
    .gnt_o  (arb_gnt),
    .vld_o  (arb_vld)
  );

  always_comb begin
    gnt_idx = '0;
    for (int k = 0; k < PORTNUM; k++) begin
      if (arb_gnt[k]) gnt_idx = SW'(k);
    end
  end

  // View of the granted channel only; every other channel is ignored.
  assign ch_vld  = i_data_vld[sel_q];
  assign ch_sop  = i_sop[sel_q];
  assign ch_eop  = i_eop[sel_q];
  assign ch_data = i_data[int'(sel_q)*DWIDTH +: DWIDTH];

  // Stop forwarding once eop has gone out; the FSM leaves S_RECV next edge.
  assign fwd         = (state_q == S_RECV) && !wr_eop_q;
  assign hdr_now     = fwd && ch_vld && !hdr_seen_q;
  assign hdr_blk_now = hdr_blocks(ch_data[16:7]);
  assign timeout_hit = fwd && !ch_vld && (idle_cnt_q == TW'(TIMEOUT - 1));

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    sel_d      = sel_q;
    src_id_d   = src_id_q;
    resp_d     = '0;
    wr_en_d    = 1'b0;
    wr_sop_d   = 1'b0;
    wr_eop_d   = 1'b0;
    wr_abort_d = 1'b0;
    wr_data_d  = '0;
    hdr_seen_d = hdr_seen_q;
    hdr_blk_d  = hdr_blk_q;
    idle_cnt_d = '0;

    case (state_q)
      S_IDLE: begin
        if (arb_vld) begin
          sel_d   = gnt_idx;
          last_d  = gnt_idx;
          state_d = S_GRANT;
        end
      end
      S_GRANT: begin
        resp_d[sel_q] = 1'b1;
        src_id_d      = sel_q;
        hdr_seen_d    = 1'b0;
        hdr_blk_d     = '0;
        state_d       = S_RECV;
      end
      S_RECV: begin
        if (fwd) begin
          wr_en_d   = ch_vld;
          wr_sop_d  = ch_sop;
          wr_eop_d  = ch_eop;
          wr_data_d = ch_data;
        end
        if (hdr_now) begin
          hdr_seen_d = 1'b1;
          hdr_blk_d  = hdr_blk_now;
        end
        if (fwd && !ch_vld && !timeout_hit) idle_cnt_d = idle_cnt_q + TW'(1);
        if (timeout_hit) wr_abort_d = 1'b1;
        if (wr_eop_q || timeout_hit) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Refuse every request not granted this cycle; a request from the channel
    // about to receive its grant is covered by that grant.
    nresp_d = i_req & ~((state_q == S_IDLE) ? arb_gnt : '0) & ~resp_d;
  end

  // Free-space update: returned blocks and abort restore add, header
  // subtraction removes, all netted before clamping to [0, RAM_BLOCKS].
  always_comb begin
    add_sum = EW'(space_q)
            + (i_free_vld  ? EW'(i_free_blocks) : '0)
            + (timeout_hit ? EW'(hdr_blk_q)     : '0);
    sub_amt   = hdr_now ? EW'(hdr_blk_now) : '0;
    underflow = add_sum < sub_amt;
    net       = add_sum - sub_amt;
    if (underflow)                 space_d = '0;
    else if (net > EW'(RAM_MAX))   space_d = RAM_MAX;
    else                           space_d = RAMWIDTH'(net);
  end

  assert property (@(posedge i_clk) disable iff (!i_rst_n) !underflow);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= S_IDLE;
      last_q     <= SW'(PORTNUM - 1);
      sel_q      <= '0;
      src_id_q   <= '0;
      resp_q     <= '0;
      nresp_q    <= '0;
      wr_en_q    <= 1'b0;
      wr_sop_q   <= 1'b0;
      wr_eop_q   <= 1'b0;
      wr_abort_q <= 1'b0;
      wr_data_q  <= '0;
      space_q    <= RAM_MAX;
      hdr_seen_q <= 1'b0;
      hdr_blk_q  <= '0;
      idle_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      sel_q      <= sel_d;
      src_id_q   <= src_id_d;
      resp_q     <= resp_d;
      nresp_q    <= nresp_d;
      wr_en_q    <= wr_en_d;
      wr_sop_q   <= wr_sop_d;
      wr_eop_q   <= wr_eop_d;
      wr_abort_q <= wr_abort_d;
      wr_data_q  <= wr_data_d;
      space_q    <= space_d;
      hdr_seen_q <= hdr_seen_d;
      hdr_blk_q  <= hdr_blk_d;
      idle_cnt_q <= idle_cnt_d;
    end
  end

  assign o_ready    = (state_q == S_IDLE);
  assign o_resp     = resp_q;
  assign o_nresp    = nresp_q;
  assign o_ramspace = space_q;
  assign o_wr_en    = wr_en_q;
  assign o_wr_sop   = wr_sop_q;
  assign o_wr_eop   = wr_eop_q;
  assign o_wr_abort = wr_abort_q;
  assign o_wr_data  = wr_data_q;
  assign o_src_id   = src_id_q;

endmodule
